sram_req_arbiter: RTL and testbench

Shares one SRAM-like memory port between the IF-stage instruction requester and the EX-stage data requester (data_sram_req/addr_ok/data_ok protocol). It sits between the pipeline stages and the SRAM-to-AXI bridge. Fixed data-over-instruction priority applies, with an anti-starvation counter for the instruction side. An in-order owner FIFO tracks outstanding requests so that each data_ok/rdata response is routed back to the requester that issued it.

---
 rtl/sram_req_arbiter_pkg.sv | 20 ++
 rtl/sram_req_arbiter_if.sv | 26 ++
 rtl/sram_req_arbiter_owner_fifo.sv | 62 ++++++
 rtl/sram_req_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM-like request arbiter: owner encoding,
// FSM state encoding and bus field widths.
package sram_req_arbiter_pkg;

  localparam int SIZE_W = 2;
  localparam int STRB_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Owner bit stored in the in-order FIFO.
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_D = 2'd1,
    ST_LOCK_I = 2'd2
  } state_t;

endpackage

// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response bus (req/addr_ok/data_ok protocol).
// master drives the request fields, slave answers with addr_ok/data_ok/rdata.
interface sram_req_arbiter_if;
  import sram_req_arbiter_pkg::*;

  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [STRB_W-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_req_arbiter_owner_fifo.sv
// 1-bit wide in-order FIFO recording which requester owns each accepted,
// not-yet-answered request.
module sram_req_arbiter_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] slots;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage and pointers; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slots  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy count; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like memory port between the instruction and data
// requesters. Data has priority; the instruction side is forced ahead after
// STARVE_LIM data grants while it waits. Responses are routed back in order
// using the owner FIFO.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | free to arbitrate; grant decided combinationally this cycle
// ST_LOCK_D | data granted but not yet accepted; mux held on data
// ST_LOCK_I | inst granted but not yet accepted; mux held on inst
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  sram_req_arbiter_if.slave    inst_bus,
  sram_req_arbiter_if.slave    data_bus,
  sram_req_arbiter_if.master   mem_bus,
  output logic                 resp_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  state_t        state;
  state_t        state_nxt;
  logic          grant_vld;
  logic          owner;
  logic          owner_req;
  logic          mem_req;
  logic          hs;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_head;
  logic [CW-1:0] fifo_count;
  logic [SW-1:0] starve_cnt;
  logic          starve_hit;

  assign starve_hit = (starve_cnt == SW'(STARVE_LIM));
  assign owner_req  = (owner == OWN_DATA) ? data_bus.req : inst_bus.req;
  assign mem_req    = grant_vld & owner_req;
  assign hs         = mem_req & mem_bus.addr_ok;
  // Count is used directly so a response is never popped from an empty FIFO.
  assign pop        = resetn & mem_bus.data_ok & (fifo_count != '0);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state: lock onto the owner until its request is accepted or dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_vld && !mem_bus.addr_ok)
          state_nxt = (owner == OWN_DATA) ? ST_LOCK_D : ST_LOCK_I;
      end
      ST_LOCK_D, ST_LOCK_I: begin
        if (!owner_req || mem_bus.addr_ok) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: grant decision, request mux and response routing.
  always_comb begin
    grant_vld = 1'b0;
    owner     = OWN_DATA;
    case (state)
      ST_IDLE: begin
        if (resetn && !fifo_full) begin
          if (inst_bus.req && starve_hit) begin
            grant_vld = 1'b1;
            owner     = OWN_INST;
          end else if (data_bus.req) begin
            grant_vld = 1'b1;
            owner     = OWN_DATA;
          end else if (inst_bus.req) begin
            grant_vld = 1'b1;
            owner     = OWN_INST;
          end
        end
      end
      ST_LOCK_D: begin
        grant_vld = resetn;
        owner     = OWN_DATA;
      end
      ST_LOCK_I: begin
        grant_vld = resetn;
        owner     = OWN_INST;
      end
      default: ;
    endcase

    mem_bus.req   = mem_req;
    mem_bus.wr    = 1'b0;
    mem_bus.size  = '0;
    mem_bus.wstrb = '0;
    mem_bus.addr  = '0;
    mem_bus.wdata = '0;
    if (grant_vld) begin
      if (owner == OWN_DATA) begin
        mem_bus.wr    = data_bus.wr;
        mem_bus.size  = data_bus.size;
        mem_bus.wstrb = data_bus.wstrb;
        mem_bus.addr  = data_bus.addr;
        mem_bus.wdata = data_bus.wdata;
      end else begin
        mem_bus.wr    = inst_bus.wr;
        mem_bus.size  = inst_bus.size;
        mem_bus.wstrb = inst_bus.wstrb;
        mem_bus.addr  = inst_bus.addr;
        mem_bus.wdata = inst_bus.wdata;
      end
    end

    inst_bus.addr_ok = hs & (owner == OWN_INST);
    data_bus.addr_ok = hs & (owner == OWN_DATA);
    inst_bus.data_ok = pop & (fifo_head == OWN_INST);
    data_bus.data_ok = pop & (fifo_head == OWN_DATA);
    inst_bus.rdata   = resetn ? mem_bus.rdata : '0;
    data_bus.rdata   = resetn ? mem_bus.rdata : '0;
  end

  // Anti-starvation counter: data grants taken while inst is waiting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!inst_bus.req || (hs && owner == OWN_INST)) begin
      starve_cnt <= '0;
    end else if (hs && owner == OWN_DATA && !starve_hit) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Sticky error: a response with nothing outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            resp_err <= 1'b0;
    else if (mem_bus.data_ok && fifo_empty) resp_err <= 1'b1;
  end

  sram_req_arbiter_owner_fifo #(
    .DEPTH (DEPTH)
  ) u_owner_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (hs),
    .din    (owner),
    .pop    (pop),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed self-checking bench for sram_req_arbiter (DEPTH=4, STARVE_LIM=4).
module tb_sram_req_arbiter;

  logic clk;
  logic resetn;
  logic resp_err;
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   exp_q[$];
  bit   eo;
  logic [31:0] fill_addr [4];
  bit          fill_own  [4];

  sram_req_arbiter_if inst_if ();
  sram_req_arbiter_if data_if ();
  sram_req_arbiter_if mem_if ();

  sram_req_arbiter #(
    .DEPTH      (4),
    .STARVE_LIM (4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .inst_bus (inst_if),
    .data_bus (data_if),
    .mem_bus  (mem_if),
    .resp_err (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd2; inst_if.wstrb = 4'hf;
    inst_if.addr = '0; inst_if.wdata = '0;
    data_if.req = 0; data_if.wr = 0; data_if.size = 2'd2; data_if.wstrb = 4'hf;
    data_if.addr = '0; data_if.wdata = '0;
    mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = '0;
  endtask

  initial begin
    fill_addr[0] = 32'h1c000000; fill_own[0] = 1'b0;
    fill_addr[1] = 32'h00001000; fill_own[1] = 1'b1;
    fill_addr[2] = 32'h1c000004; fill_own[2] = 1'b0;
    fill_addr[3] = 32'h00001004; fill_own[3] = 1'b1;

    // Reset: everything reads 0 even with requests/responses present.
    resetn = 0;
    idle_all();
    data_if.req = 1; data_if.addr = 32'h1000;
    mem_if.data_ok = 1; mem_if.rdata = 32'hdead;
    #2;
    chk("rst_mem_req", mem_if.req, 0);
    chk("rst_data_addr_ok", data_if.addr_ok, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_data_rdata", data_if.rdata, 0);
    chk("rst_data_data_ok", data_if.data_ok, 0);
    tick(); tick();
    idle_all();
    resetn = 1;

    // Lock: data held while addr_ok low for 3 cycles, inst arrives in cycle 2.
    data_if.req = 1; data_if.wr = 1; data_if.addr = 32'h1000; data_if.wdata = 32'h55;
    #1;
    chk("lock1_mem_req", mem_if.req, 1);
    chk("lock1_mem_addr", mem_if.addr, 32'h1000);
    chk("lock1_mem_wr", mem_if.wr, 1);
    chk("lock1_data_addr_ok", data_if.addr_ok, 0);
    tick();
    inst_if.req = 1; inst_if.addr = 32'h1c000000;
    #1;
    chk("lock2_mem_addr", mem_if.addr, 32'h1000);
    chk("lock2_inst_addr_ok", inst_if.addr_ok, 0);
    tick();
    #1;
    chk("lock3_mem_addr", mem_if.addr, 32'h1000);
    chk("lock3_inst_addr_ok", inst_if.addr_ok, 0);
    tick();
    mem_if.addr_ok = 1;
    #1;
    chk("lock4_data_addr_ok", data_if.addr_ok, 1);
    chk("lock4_inst_addr_ok", inst_if.addr_ok, 0);
    tick();
    data_if.req = 0; data_if.wr = 0;
    #1;
    chk("after_lock_mem_addr", mem_if.addr, 32'h1c000000);
    chk("after_lock_inst_addr_ok", inst_if.addr_ok, 1);
    tick();
    inst_if.req = 0; mem_if.addr_ok = 0;
    #1;
    chk("two_out_mem_req", mem_if.req, 0);

    // Reset mid-transaction with two outstanding requests.
    data_if.req = 1; data_if.addr = 32'h2000;
    resetn = 0;
    #1;
    chk("midrst_mem_req", mem_if.req, 0);
    chk("midrst_resp_err", resp_err, 0);
    tick();
    data_if.req = 0; resetn = 1;
    mem_if.data_ok = 1; mem_if.rdata = 32'h77;
    #1;
    chk("stale_data_data_ok", data_if.data_ok, 0);
    chk("stale_inst_data_ok", inst_if.data_ok, 0);
    tick();
    mem_if.data_ok = 0;
    #1;
    chk("stale_resp_err", resp_err, 1);
    resetn = 0;
    #1;
    chk("rst2_resp_err", resp_err, 0);
    tick();
    resetn = 1;

    // Starvation: both requesting, addr_ok every cycle -> D,D,D,D,I.
    inst_if.req = 1; inst_if.addr = 32'h1c000000;
    data_if.req = 1; data_if.addr = 32'h2000;
    mem_if.addr_ok = 1;
    for (int k = 1; k <= 5; k++) begin
      mem_if.data_ok = (k > 1);
      mem_if.rdata = 32'(k);
      #1;
      chk($sformatf("starve%0d_data_addr_ok", k), data_if.addr_ok, (k < 5) ? 1 : 0);
      chk($sformatf("starve%0d_inst_addr_ok", k), inst_if.addr_ok, (k == 5) ? 1 : 0);
      if (k > 1) begin
        chk($sformatf("starve%0d_data_data_ok", k), data_if.data_ok, 1);
        chk($sformatf("starve%0d_data_rdata", k), data_if.rdata, 32'(k));
      end
      tick();
    end
    inst_if.req = 0; data_if.req = 0; mem_if.addr_ok = 0;
    mem_if.data_ok = 1; mem_if.rdata = 32'h6;
    #1;
    chk("starve6_inst_data_ok", inst_if.data_ok, 1);
    chk("starve6_data_data_ok", data_if.data_ok, 0);
    chk("starve6_inst_rdata", inst_if.rdata, 32'h6);
    tick();
    mem_if.data_ok = 0;
    #1;
    chk("starve_resp_err", resp_err, 0);

    // Fill to DEPTH with no responses.
    mem_if.addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      inst_if.req = !fill_own[i]; inst_if.addr = fill_addr[i];
      data_if.req = fill_own[i];  data_if.addr = fill_addr[i];
      #1;
      chk($sformatf("fill%0d_mem_addr", i), mem_if.addr, fill_addr[i]);
      chk($sformatf("fill%0d_inst_addr_ok", i), inst_if.addr_ok, fill_own[i] ? 0 : 1);
      chk($sformatf("fill%0d_data_addr_ok", i), data_if.addr_ok, fill_own[i] ? 1 : 0);
      tick();
    end
    inst_if.req = 0;
    data_if.req = 1; data_if.addr = 32'h1008;
    #1;
    chk("full_mem_req", mem_if.req, 0);
    chk("full_data_addr_ok", data_if.addr_ok, 0);
    mem_if.data_ok = 1; mem_if.rdata = 32'hA;
    #1;
    chk("full_pop_mem_req", mem_if.req, 0);
    chk("resp_A_inst_data_ok", inst_if.data_ok, 1);
    chk("resp_A_data_data_ok", data_if.data_ok, 0);
    chk("resp_A_inst_rdata", inst_if.rdata, 32'hA);
    tick();
    data_if.req = 0;
    for (int i = 1; i < 4; i++) begin
      mem_if.rdata = 32'hA + 32'(i);
      #1;
      chk($sformatf("resp%0d_inst_data_ok", i), inst_if.data_ok, fill_own[i] ? 0 : 1);
      chk($sformatf("resp%0d_data_data_ok", i), data_if.data_ok, fill_own[i] ? 1 : 0);
      if (fill_own[i]) chk($sformatf("resp%0d_data_rdata", i), data_if.rdata, 32'hA + 32'(i));
      else             chk($sformatf("resp%0d_inst_rdata", i), inst_if.rdata, 32'hA + 32'(i));
      tick();
    end
    mem_if.data_ok = 0;

    // Hold 3 outstanding, push and pop together 10 times (pointers wrap).
    for (int i = 0; i < 3; i++) begin
      inst_if.req = (i != 1); inst_if.addr = 32'h1c000100;
      data_if.req = (i == 1); data_if.addr = 32'h3000;
      exp_q.push_back(i == 1);
      #1;
      chk($sformatf("pre%0d_mem_req", i), mem_if.req, 1);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      inst_if.req = i[0]; data_if.req = !i[0];
      mem_if.data_ok = 1; mem_if.rdata = 32'h100 + 32'(i);
      eo = exp_q.pop_front();
      exp_q.push_back(!i[0]);
      #1;
      chk($sformatf("wrap%0d_mem_req", i), mem_if.req, 1);
      chk($sformatf("wrap%0d_inst_data_ok", i), inst_if.data_ok, eo ? 0 : 1);
      chk($sformatf("wrap%0d_data_data_ok", i), data_if.data_ok, eo ? 1 : 0);
      tick();
    end
    inst_if.req = 0; data_if.req = 1; mem_if.data_ok = 0;
    #1;
    chk("wrap_count3_mem_req", mem_if.req, 1);
    exp_q.push_back(1'b1);
    tick();
    #1;
    chk("wrap_full_mem_req", mem_if.req, 0);
    data_if.req = 0; mem_if.addr_ok = 0;
    for (int i = 0; i < 4; i++) begin
      mem_if.data_ok = 1;
      eo = exp_q.pop_front();
      #1;
      chk($sformatf("drain%0d_inst_data_ok", i), inst_if.data_ok, eo ? 0 : 1);
      chk($sformatf("drain%0d_data_data_ok", i), data_if.data_ok, eo ? 1 : 0);
      tick();
    end

    // Response with nothing outstanding.
    #1;
    chk("empty_inst_data_ok", inst_if.data_ok, 0);
    chk("empty_data_data_ok", data_if.data_ok, 0);
    chk("empty_pre_resp_err", resp_err, 0);
    tick();
    mem_if.data_ok = 0;
    #1;
    chk("empty_resp_err", resp_err, 1);
    tick(); tick();
    chk("empty_resp_err_held", resp_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
